// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding and default baud dividers; PARITY state exists only with UART_RX_PARITY_EN
package uart_pkg;
  localparam int T_DIV_BIT_DEF = 13;
  localparam int T_DIV_0_DEF = 5207;
  localparam int T_DIV_1_DEF = 2603;
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: power-of-two receive FIFO that drops the new word and flags overrun when full
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic rd, wr, full;
  assign valid = count != '0;
  assign full = count == CW'(DEPTH);
  assign rd = pop & valid;
  assign wr = push & (~full | rd);
  assign dout = valid ? mem[rp] : '0;
  always_ff @(posedge clk) if (wr) mem[wp] <= din;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      overrun <= 1'b0;
    end else begin
      wp <= wp + AW'(wr);
      rp <= rp + AW'(rd);
      count <= count + CW'(wr) - CW'(rd);
      overrun <= push & ~wr;
    end
endmodule

// File: rtl/uart_rx_multi.sv
// uart_rx_multi: dual-rate UART receiver with FIFO; define UART_RX_PARITY_EN for an even-parity bit
module uart_rx_multi
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int T_DIV_BIT = T_DIV_BIT_DEF,
  parameter int T_DIV_0 = T_DIV_0_DEF,
  parameter int T_DIV_1 = T_DIV_1_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          uart_rxd,
  input  logic                          baud_sel,
  input  logic                          rx_ready,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun
);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [T_DIV_BIT-1:0] D0 = T_DIV_BIT'(T_DIV_0);
  localparam logic [T_DIV_BIT-1:0] D1 = T_DIV_BIT'(T_DIV_1);
  state_t state, nxt;
  logic s0, s1, rxd_q, sel_q, fall, tick, push, ferr;
  logic [T_DIV_BIT-1:0] cnt, div;
  logic [BW-1:0] bcnt;
  logic [DATA_BITS-1:0] sh;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) {s0, s1, rxd_q} <= 3'b111;
    else {s0, s1, rxd_q} <= {uart_rxd, s0, s1};
  assign fall = rxd_q & ~s1;
  assign div = sel_q ? D1 : D0;
  assign tick = cnt == (state == START ? div >> 1 : div);
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = fall ? START : IDLE;
      START: if (tick) nxt = s1 ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA: if (tick && bcnt == BW'(DATA_BITS - 1)) nxt = PARITY;
      PARITY: if (tick) nxt = STOP;
`else
      DATA: if (tick && bcnt == BW'(DATA_BITS - 1)) nxt = STOP;
`endif
      STOP: if (tick) nxt = s1 ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (s1) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    push = state == STOP && tick && s1;
    ferr = state == STOP && tick && !s1;
  end
  // baud rate is frozen at the start edge so mid-frame baud_sel changes are ignored
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      cnt <= '0;
      bcnt <= '0;
      sh <= '0;
      sel_q <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cnt <= (state == IDLE || state == WAIT_IDLE || tick) ? '0 : cnt + T_DIV_BIT'(1);
      if (state == IDLE && fall) sel_q <= baud_sel;
      if (state == DATA && tick) begin
        sh <= {s1, sh[DATA_BITS-1:1]};
        bcnt <= bcnt + BW'(1);
      end else if (state != DATA) bcnt <= '0;
      frame_err <= ferr;
    end
`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) parity_err <= 1'b0;
    else parity_err <= state == PARITY && tick && (^sh ^ s1);
`else
  assign parity_err = 1'b0;
`endif
  uart_rx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .n_rst(n_rst),
    .push(push),
    .din(sh),
    .pop(rx_ready),
    .dout(rx_data),
    .valid(rx_valid),
    .count(fifo_count),
    .overrun(overrun)
  );
endmodule

// File: tb/tb_uart_rx_multi.sv
// tb_uart_rx_multi: directed frames at both rates, glitch, framing error, overrun and mid-frame reset
module tb_uart_rx_multi;
  import uart_pkg::*;
  logic clk = 1'b0, n_rst = 1'b0, uart_rxd = 1'b1, baud_sel = 1'b0, rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, parity_err, overrun;
  logic [2:0] fifo_count;
  int n_cmp = 0, n_bad = 0, fe_cnt = 0, pe_cnt = 0, ov_cnt = 0, cyc = 0, t0 = 0;
  uart_rx_multi #(.DATA_BITS(8), .T_DIV_BIT(4), .T_DIV_0(15), .T_DIV_1(7), .FIFO_DEPTH(4)) dut (
    .clk(clk),
    .n_rst(n_rst),
    .uart_rxd(uart_rxd),
    .baud_sel(baud_sel),
    .rx_ready(rx_ready),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .fifo_count(fifo_count),
    .frame_err(frame_err),
    .parity_err(parity_err),
    .overrun(overrun)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (parity_err) pe_cnt <= pe_cnt + 1;
    if (overrun) ov_cnt <= ov_cnt + 1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic bitt(input logic v, input int n);
    uart_rxd = v;
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] d, input int n, input logic stop, input logic tog);
    t0 = cyc;
    bitt(1'b0, n);
    for (int i = 0; i < 8; i++) begin
      bitt(d[i], n);
      if (tog && i == 3) baud_sel = ~baud_sel;
    end
`ifdef UART_RX_PARITY_EN
    bitt(^d, n);
`endif
    bitt(stop, n);
    uart_rxd = 1'b1;
  endtask
  task automatic wait_valid(input string tag);
    int k = 0;
    while (!rx_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(tag, rx_valid, 1);
  endtask
  task automatic pop(input string tag, input logic [7:0] exp);
    chk(tag, rx_data, exp);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", rx_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_flags", {frame_err, parity_err, overrun}, 0);
    n_rst = 1'b1;
    repeat (4) @(negedge clk);
    send(8'hC5, 16, 1'b1, 1'b0);
    wait_valid("c5_valid");
    chk("c5_latency", cyc - t0 <= 164, 1);
    chk("c5_data", rx_data, 8'hC5);
    chk("c5_flags", fe_cnt + pe_cnt + ov_cnt, 0);
    pop("c5_pop", 8'hC5);
    chk("c5_empty", fifo_count, 0);
    baud_sel = 1'b1;
    send(8'hC6, 8, 1'b1, 1'b1);
    wait_valid("c6_valid");
    chk("c6_count", fifo_count, 1);
    pop("c6_pop", 8'hC6);
    baud_sel = 1'b0;
    repeat (4) @(negedge clk);
    bitt(1'b0, 3);
    bitt(1'b1, 30);
    chk("glitch_state", dut.state, IDLE);
    chk("glitch_count", fifo_count, 0);
    chk("glitch_flags", fe_cnt + pe_cnt + ov_cnt, 0);
    send(8'h3C, 16, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    chk("ferr_pulse", fe_cnt, 1);
    chk("ferr_count", fifo_count, 0);
    send(8'hC7, 16, 1'b1, 1'b0);
    wait_valid("c7_valid");
    pop("c7_pop", 8'hC7);
    chk("c7_ferr", fe_cnt, 1);
    baud_sel = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(8'hC0 + 8'(i), 8, 1'b1, 1'b0);
      repeat (4) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    chk("ovr_count", fifo_count, 4);
    chk("ovr_pulse", ov_cnt, 1);
    for (int i = 0; i < 4; i++) pop("ovr_pop", 8'hC0 + 8'(i));
    chk("ovr_empty", {rx_valid, fifo_count}, 0);
    baud_sel = 1'b0;
    send(8'hAA, 16, 1'b1, 1'b0);
    wait_valid("pre_rst_valid");
    bitt(1'b0, 16);
    bitt(1'b1, 16);
    bitt(1'b0, 16);
    n_rst = 1'b0;
    #1;
    chk("mid_rst_valid", rx_valid, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_data", rx_data, 0);
    chk("mid_rst_flags", {frame_err, parity_err, overrun}, 0);
    @(negedge clk);
    uart_rxd = 1'b1;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (4) @(negedge clk);
    send(8'hC8, 16, 1'b1, 1'b0);
    wait_valid("c8_valid");
    pop("c8_pop", 8'hC8);
    chk("c8_empty", fifo_count, 0);
    chk("final_flags", {fe_cnt[7:0], pe_cnt[7:0], ov_cnt[7:0]}, 24'h010001);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
